keypad_encoder: RTL and testbench
=================================

# keypad_encoder

Front-end conditioning stage between raw push-button inputs and the digit-entry logic. Synchronises the 16 hex-key buttons and the shift button, debounces them, and turns each accepted press into a single-cycle strobe with a 4-bit key code. Chords of two or more keys are rejected. The downstream digit-entry stage consumes `key_valid`/`key_code`/`shift_pulse` instead of level-sensitive one-hot buttons.

## Interface
- `DEBOUNCE_CYCLES`, default 2: consecutive stable synchronised samples required to accept a press or release. Minimum 1; 20 ms at 100 Hz.
- `REPEAT_DELAY`, default 50: HELD cycles before the first auto-repeat (used only with `KEY_REPEAT_EN`).
- `REPEAT_RATE`, default 10: cycles between subsequent auto-repeats (used only with `KEY_REPEAT_EN`).
- `CLK`  in  1  system clock; the single clock domain.
- `NRST`  in  1  reset, asynchronous, active-low.
- `pb`  in  16  raw asynchronous key buttons; bit i = hex key i.
- `shift_btn`  in  1  raw asynchronous shift/advance button.
- `key_valid`  out  1  one-cycle strobe: accepted key press.
- `key_code`  out  4  index of the accepted key; meaningful when `key_valid`=1, holds its last value otherwise.
- `key_held`  out  1  high while an accepted single key remains pressed (state HELD).
- `shift_pulse`  out  1  one-cycle strobe on the debounced rising edge of `shift_btn`.
- `chord_err`  out  1  one-cycle strobe when a debounced multi-key pattern is rejected.

## Operation
- Both `pb` and `shift_btn` pass through a 2-flop synchroniser, producing `sync_pb` and `sync_sh`. The FSM sees only synchronised values.
- The FSM has a registered snapshot `snap[15:0]` and a counter `cnt` of width clog2(max(`DEBOUNCE_CYCLES`, `REPEAT_DELAY`, `REPEAT_RATE`)+1).
- **IDLE**
  - `sync_pb`=0: stay.
  - Otherwise: `snap`<=`sync_pb`, `cnt`<=0, go to SETTLE.
- **SETTLE**
  - `sync_pb`=0: go to IDLE, with no output.
  - `sync_pb`≠`snap` and nonzero: recapture `snap`, `cnt`<=0.
  - `sync_pb`=`snap` and `cnt`=`DEBOUNCE_CYCLES`-1:
    - `snap` one-hot: pulse `key_valid`, `key_code`<=index, go to HELD.
    - `snap` multi-hot: pulse `chord_err`, go to RELEASE.
  - Otherwise: `cnt`++.
- **HELD**
  - `key_held`=1.
  - Any change of `sync_pb` from `snap`, including adding a second key: `cnt`<=0, go to RELEASE. No new code is emitted until a full release.
- **RELEASE**
  - `sync_pb`≠0: `cnt`<=0.
  - `sync_pb`=0 for `DEBOUNCE_CYCLES` consecutive cycles: go to IDLE.
- **Shift path**: independent of the FSM. Its own debounce counter accepts a new level after `DEBOUNCE_CYCLES` stable samples. `shift_pulse`=1 for one cycle on an accepted 0→1 level. A shift event and a key event in the same cycle both strobe.
- **Reset values**:
  - FSM state IDLE.
  - `snap`, `cnt`, synchroniser flops and the debounced shift level are 0.
  - All outputs are 0, including `key_code`=0.
- **Reset mid-operation**: any assertion of `NRST` discards a pending press or repeat immediately. After release, a button still held is seen as a new press and must debounce from scratch.

## Timing
- All outputs come directly from flops; no combinational input-to-output path.
- A press stable before rising edge E1 raises `key_valid` for exactly one cycle, starting at edge E(`DEBOUNCE_CYCLES`+3). With the default this is E5: 2 edges for the synchroniser, 1 for IDLE→SETTLE, `DEBOUNCE_CYCLES` for settling.
- `shift_pulse` uses the same latency, measured from a `shift_btn` rise.
- `key_held` rises in the same cycle as `key_valid`. It falls one cycle after `sync_pb` first differs from `snap`.
- Minimum time between two distinct accepted presses: 2×`DEBOUNCE_CYCLES`+2 cycles.

## Configuration
- **`KEY_REPEAT_EN` defined**:
  - In HELD, `cnt` counts up. At `REPEAT_DELAY` it pulses `key_valid` with the same `key_code`, then pulses again every `REPEAT_RATE` cycles while HELD.
  - Leaving HELD cancels repeat immediately.
- **`KEY_REPEAT_EN` undefined**:
  - Exactly one `key_valid` per accepted press.
  - The `REPEAT_*` parameters are ignored.

## Structure
- Shared package `keypad_pkg` holds:
  - the state enum `kp_state_t` (IDLE, SETTLE, HELD, RELEASE);
  - the 4-bit `key_code_t` typedef;
  - the one-hot→index and one-hot-check functions.
- One sub-module, `debounce_bit`: 2-flop synchroniser, stability counter and rising-edge strobe for a single bit. It is instantiated for `shift_btn`. The 16-bit key path stays in the parent because chord detection needs the whole vector.

## Test plan
- Hold `pb`=16'h0008 for 20 cycles, then release, with the default parameters → exactly one `key_valid` at E5 with `key_code`=3. `key_held` is high until 1 cycle after `sync_pb`=0.
- Toggle `pb[5]` every cycle for 10 cycles, then hold it → no strobe during toggling; one `key_valid`, `key_code`=5, `DEBOUNCE_CYCLES`+3 edges after the last toggle stabilises.
- Hold `pb`=16'h0104 → `chord_err` pulses once and `key_valid` never asserts. Releasing to 0 returns the FSM to IDLE after 2 stable zero cycles.
- Hold key F, then add key 2 without releasing → one `key_valid` with code 15 and none for key 2 until all keys are released and key 2 is pressed again.
- Assert `NRST` low during SETTLE of key A, release it while A is still held → all outputs 0 during reset; after release, `key_valid` with code 10 at `DEBOUNCE_CYCLES`+3 edges.
- With `KEY_REPEAT_EN` defined, hold key 7 for 100 cycles, default parameters → `key_valid` at press, then at +50, +60, +70, +80, +90 cycles relative to the first strobe, all with code 7.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad encoder: FSM states, key code type,
// one-hot decoding and counter sizing.
package keypad_pkg;

  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned CODE_W   = 4;

  typedef logic [CODE_W-1:0]   key_code_t;
  typedef logic [NUM_KEYS-1:0] key_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } kp_state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input key_vec_t v);
    return (v != '0) && ((v & (v - key_vec_t'(1))) == '0);
  endfunction

  // Index of the set bit; only meaningful for a one-hot argument.
  function automatic key_code_t onehot_to_idx(input key_vec_t v);
    key_code_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, stability counter and a
// one-cycle strobe on each accepted 0->1 level.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = sync_q;
        rise_d  = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/keypad_encoder.sv
// Hex keypad front end: synchronise, debounce and encode single key presses,
// reject chords, and strobe the shift button. Define KEY_REPEAT_EN for auto-repeat.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [15:0] pb,
  input  logic        shift_btn,
  output logic        key_valid,
  output key_code_t   key_code,
  output logic        key_held,
  output logic        shift_pulse,
  output logic        chord_err
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);

  key_vec_t         pb_meta_q;
  key_vec_t         sync_pb_q;

  kp_state_t        state_q, state_d;
  key_vec_t         snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_valid_q, key_valid_d;
  key_code_t        key_code_q, key_code_d;
  logic             key_held_q, key_held_d;
  logic             chord_err_q, chord_err_d;

`ifdef KEY_REPEAT_EN
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] rep_limit_c;
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pb_meta_q <= '0;
      sync_pb_q <= '0;
    end else begin
      pb_meta_q <= pb;
      sync_pb_q <= pb_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      chord_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      chord_err_q <= chord_err_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) rep_q <= 1'b0;
    else       rep_q <= rep_d;
  end

  // First repeat waits the long delay, later ones the shorter rate.
  assign rep_limit_c = rep_q ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1);
`endif

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    chord_err_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d       = rep_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (sync_pb_q != '0) begin
          snap_d  = sync_pb_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (sync_pb_q == '0) begin
          state_d = IDLE;
        end else if (sync_pb_q != snap_q) begin
          snap_d = sync_pb_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d = '0;
          if (is_onehot(snap_q)) begin
            key_valid_d = 1'b1;
            key_code_d  = onehot_to_idx(snap_q);
            state_d     = HELD;
`ifdef KEY_REPEAT_EN
            rep_d       = 1'b0;
`endif
          end else begin
            chord_err_d = 1'b1;
            state_d     = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Any deviation from the accepted key, including a second key, ends the press.
      HELD: begin
        if (sync_pb_q != snap_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
`ifdef KEY_REPEAT_EN
        end else if (cnt_q == rep_limit_c) begin
          key_valid_d = 1'b1;
          cnt_d       = '0;
          rep_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      RELEASE: begin
        if (sync_pb_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    key_held_d = (state_d == HELD);
  end

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_shift_db (
    .clk   (CLK),
    .rst_n (NRST),
    .d_i   (shift_btn),
    .rise_o(shift_pulse)
  );

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign chord_err = chord_err_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed scenarios plus random key/shift traffic,
// every cycle compared against a history-based behavioural model.
module tb_keypad_encoder;

  localparam int DEB   = 2;
  localparam int RDLY  = 50;
  localparam int RRATE = 10;

  localparam int PH_READY = 0;
  localparam int PH_QUAL  = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_DRAIN = 3;

  logic        CLK;
  logic        NRST;
  logic [15:0] pb;
  logic        shift_btn;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic        shift_pulse;
  logic        chord_err;

  keypad_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_RATE    (RRATE)
  ) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .pb         (pb),
    .shift_btn  (shift_btn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_held   (key_held),
    .shift_pulse(shift_pulse),
    .chord_err  (chord_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests;
  int fails;
  int tk;

  // Reference model state: input delay line, sample histories, press phase.
  logic [15:0] m_p1, m_p2;
  logic        m_s1, m_s2;
  logic [15:0] hist[$];
  logic        shist[$];
  int          ph;
  logic [15:0] pat;
  int          since;
  int          medge;
  int          dstart;
  logic [3:0]  m_code;
  logic        m_lvl;
  logic        e_valid, e_chord, e_held, e_shift;

  // Directed segment statistics taken from the DUT outputs.
  int seg_t0, seg_v, seg_c, seg_s, first_v, first_s, bad_code;
  int vt[$];
  logic [3:0] last_code;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h tick=%0d", tag, obs, exp, tk);
    end
  endtask

  function automatic int run_pb(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == v) n++;
      else break;
    end
    return n;
  endfunction

  function automatic int run_sh(input logic v);
    int n;
    n = 0;
    for (int i = shist.size() - 1; i >= 0; i--) begin
      if (shist[i] == v) n++;
      else break;
    end
    return n;
  endfunction

  function automatic logic [3:0] idx_of(input logic [15:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_s1 = 1'b0; m_s2 = 1'b0;
    hist.delete(); shist.delete();
    ph = PH_READY; pat = '0; since = 0; medge = 0; dstart = 0;
    m_code = 4'h0; m_lvl = 1'b0;
    e_valid = 1'b0; e_chord = 1'b0; e_held = 1'b0; e_shift = 1'b0;
  endtask

  // One rising edge of the model; p/sh are the raw inputs present at that edge.
  task automatic model_step(input logic [15:0] p, input logic sh);
    logic [15:0] s;
    logic        ss;
    int          r;
    s = m_p2; m_p2 = m_p1; m_p1 = p;
    ss = m_s2; m_s2 = m_s1; m_s1 = sh;
    medge++;
    hist.push_back(s);
    if (hist.size() > 64) void'(hist.pop_front());
    shist.push_back(ss);
    if (shist.size() > 64) void'(shist.pop_front());
    e_valid = 1'b0;
    e_chord = 1'b0;
    e_shift = 1'b0;

    case (ph)
      PH_READY: if (s != '0) ph = PH_QUAL;
      PH_QUAL: begin
        if (s == '0) ph = PH_READY;
        else if (run_pb(s) == DEB + 1) begin
          if ($countones(s) == 1) begin
            e_valid = 1'b1; m_code = idx_of(s); pat = s; since = 0; ph = PH_HOLD;
          end else begin
            e_chord = 1'b1; dstart = medge; ph = PH_DRAIN;
          end
        end
      end
      PH_HOLD: begin
        since++;
        if (s != pat) begin
          dstart = medge; ph = PH_DRAIN;
        end
`ifdef KEY_REPEAT_EN
        else if (since >= RDLY && ((since - RDLY) % RRATE) == 0) e_valid = 1'b1;
`endif
      end
      default: begin
        if (s == '0) begin
          r = run_pb(16'h0);
          if (r > medge - dstart) r = medge - dstart;
          if (r == DEB) ph = PH_READY;
        end
      end
    endcase
    e_held = (ph == PH_HOLD);

    if (run_sh(~m_lvl) == DEB + 1) begin
      m_lvl   = ~m_lvl;
      e_shift = m_lvl;
    end
  endtask

  task automatic seg_begin();
    seg_t0 = tk; seg_v = 0; seg_c = 0; seg_s = 0;
    first_v = -1; first_s = -1; bad_code = 0;
    vt.delete();
  endtask

  task automatic tick(input logic [15:0] p, input logic sh);
    @(negedge CLK);
    pb = p;
    shift_btn = sh;
    @(posedge CLK);
    tk++;
    model_step(p, sh);
    #1;
    check("key_valid",   16'(key_valid),   16'(e_valid));
    check("key_code",    16'(key_code),    16'(m_code));
    check("key_held",    16'(key_held),    16'(e_held));
    check("chord_err",   16'(chord_err),   16'(e_chord));
    check("shift_pulse", 16'(shift_pulse), 16'(e_shift));
    if (key_valid) begin
      seg_v++;
      vt.push_back(tk - seg_t0);
      if (first_v < 0) first_v = tk - seg_t0;
      last_code = key_code;
    end
    if (chord_err) seg_c++;
    if (shift_pulse) begin
      seg_s++;
      if (first_s < 0) first_s = tk - seg_t0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 16'(key_valid),   16'h0);
    check({tag, "_code"},  16'(key_code),    16'h0);
    check({tag, "_held"},  16'(key_held),    16'h0);
    check({tag, "_shift"}, 16'(shift_pulse), 16'h0);
    check({tag, "_chord"}, 16'(chord_err),   16'h0);
  endtask

  // Asynchronous reset asserted between edges, released clear of the next edge.
  task automatic apply_reset();
    @(negedge CLK);
    NRST = 1'b0;
    #1;
    model_reset();
    check_zero_outputs("rst_async");
    repeat (2) @(posedge CLK);
    #1;
    check_zero_outputs("rst_hold");
    #1;
    NRST = 1'b1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(16'h0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at tick %0d", tk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] one, a, b, p;
    logic        sh_lvl, sh;
    int          kind, len;
    int          exp_off[6];

    tests = 0; fails = 0; tk = 0;
    one = 16'h0001;
    NRST = 1'b0;
    pb = '0;
    shift_btn = 1'b0;
    model_reset();
    #2;
    check_zero_outputs("por");
    repeat (2) @(posedge CLK);
    #2;
    NRST = 1'b1;
    idle_ticks(4);

    // Key 3 together with a shift press, then release.
    seg_begin();
    for (int i = 0; i < 20; i++) tick(16'h0008, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(16'h0000, 1'b0);
      if (i == 1) check("k3_held_before_fall", 16'(key_held), 16'h1);
      if (i == 2) check("k3_held_after_fall",  16'(key_held), 16'h0);
    end
    check("k3_count",       16'(seg_v),     16'h1);
    check("k3_latency",     16'(first_v),   16'(DEB + 3));
    check("k3_code",        16'(last_code), 16'h3);
    check("shift_count",    16'(seg_s),     16'h1);
    check("shift_latency",  16'(first_s),   16'(DEB + 3));

    // Key 5 bouncing, then held.
    seg_begin();
    for (int i = 0; i < 10; i++) tick((i % 2 == 0) ? 16'h0020 : 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) tick(16'h0020, 1'b0);
    idle_ticks(8);
    check("bounce_count",   16'(seg_v),     16'h1);
    check("bounce_latency", 16'(first_v),   16'(10 + DEB + 3));
    check("bounce_code",    16'(last_code), 16'h5);

    // Two-key chord, then minimal release before the next press.
    seg_begin();
    for (int i = 0; i < 10; i++) tick(16'h0104, 1'b0);
    for (int i = 0; i < DEB; i++) tick(16'h0000, 1'b0);
    check("chord_count",    16'(seg_c), 16'h1);
    check("chord_novalid",  16'(seg_v), 16'h0);
    seg_begin();
    for (int i = 0; i < 8; i++) tick(16'h0002, 1'b0);
    idle_ticks(8);
    check("after_chord_latency", 16'(first_v),   16'(DEB + 3));
    check("after_chord_code",    16'(last_code), 16'h1);

    // Key F held, key 2 added, then a fresh key 2 press.
    seg_begin();
    for (int i = 0; i < 10; i++) tick(16'h8000, 1'b0);
    for (int i = 0; i < 10; i++) tick(16'h8004, 1'b0);
    idle_ticks(8);
    check("f_then_2_count", 16'(seg_v),     16'h1);
    check("f_then_2_code",  16'(last_code), 16'hF);
    seg_begin();
    for (int i = 0; i < 10; i++) tick(16'h0004, 1'b0);
    idle_ticks(8);
    check("repress_2_count", 16'(seg_v),     16'h1);
    check("repress_2_code",  16'(last_code), 16'h2);

    // Reset while key A settles; key A still held afterwards.
    seg_begin();
    for (int i = 0; i < 3; i++) tick(16'h0400, 1'b0);
    pb = 16'h0400;
    apply_reset();
    seg_begin();
    for (int i = 0; i < 10; i++) tick(16'h0400, 1'b0);
    idle_ticks(8);
    check("rst_a_count",   16'(seg_v),     16'h1);
    check("rst_a_latency", 16'(first_v),   16'(DEB + 3));
    check("rst_a_code",    16'(last_code), 16'hA);

    // Key 7 held for 100 cycles.
    seg_begin();
    for (int i = 0; i < 100; i++) begin
      tick(16'h0080, 1'b0);
      if (key_valid && key_code != 4'h7) bad_code++;
    end
    idle_ticks(8);
    check("k7_codes", 16'(bad_code), 16'h0);
`ifdef KEY_REPEAT_EN
    exp_off = '{0, 50, 60, 70, 80, 90};
    check("k7_repeat_count", 16'(vt.size()), 16'h6);
    for (int i = 0; i < 6 && i < vt.size(); i++)
      check("k7_repeat_offset", 16'(vt[i] - vt[0]), 16'(exp_off[i]));
`else
    exp_off = '{0, 0, 0, 0, 0, 0};
    check("k7_single_count", 16'(vt.size()), 16'h1);
    check("k7_single_latency", 16'(first_v), 16'(DEB + 3 + exp_off[0]));
`endif

    // Random traffic: idle, single keys, chords, bounce, added keys, short taps.
    sh_lvl = 1'b0;
    for (int sg = 0; sg < 160; sg++) begin
      kind = int'($urandom_range(0, 5));
      len  = int'($urandom_range(1, 12));
      a = one << $urandom_range(0, 15);
      b = one << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) sh_lvl = ~sh_lvl;
      if ($urandom_range(0, 24) == 0) apply_reset();
      for (int i = 0; i < len; i++) begin
        case (kind)
          0:       p = 16'h0000;
          1:       p = a;
          2:       p = a | b;
          3:       p = (i % 2 == 1) ? a : 16'h0000;
          4:       p = (i < len / 2) ? a : (a | b);
          default: p = (i < len - 1) ? a : 16'h0000;
        endcase
        sh = ($urandom_range(0, 7) == 0) ? ~sh_lvl : sh_lvl;
        tick(p, sh);
      end
    end
    idle_ticks(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
